// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
package demux_pkg;
    localparam int DEMUX_WIDTH = 8;
    localparam int CNT_W       = 8;

    localparam logic SEL_CH1 = 1'b0;
    localparam logic SEL_CH2 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding buffer with valid/ready drain and same-cycle refill.
// The current slot state is exported on `state` for observation.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = DEMUX_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_accept,
    output slot_state_e  state
);
    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_d = SLOT_FULL;
                    data_d  = wr_data;
                end
            end
            SLOT_FULL: begin
                // A write into a full slot only happens when the word is leaving.
                if (rd_ready) begin
                    if (wr_en) begin
                        data_d = wr_data;
                    end else begin
                        state_d = SLOT_EMPTY;
                    end
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid      = (state_q == SLOT_FULL);
    assign data       = data_q;
    assign can_accept = (state_q == SLOT_EMPTY) || rd_ready;
    assign state      = state_q;
endmodule

// File: rtl/demux8bit2way_buf.sv
// Registered 1-to-2 demux: steers a tagged producer stream into two buffered channels.
// Optional per-channel acceptance counters when DEMUX_STATUS_EN is defined.
module demux8bit2way_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_STATUS_EN
    ,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
`endif
);
    // Handshake: a word moves on any cycle where valid && ready at the rising edge.
    // in_ready depends only on the addressed slot, never on in_valid.
    logic        acc1, acc2;
    logic        wr1, wr2;
    slot_state_e slot1_state, slot2_state;

    always_comb begin
        in_ready = (in_sel == SEL_CH1) ? acc1 : acc2;
        wr1      = in_valid && in_ready && (in_sel == SEL_CH1);
        wr2      = in_valid && in_ready && (in_sel == SEL_CH2);
    end

    demux_slot #(.W(WIDTH)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr1),
        .wr_data    (in_data),
        .rd_ready   (out1_ready),
        .valid      (out1_valid),
        .data       (out1_data),
        .can_accept (acc1),
        .state      (slot1_state)
    );

    demux_slot #(.W(WIDTH)) u_slot2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr2),
        .wr_data    (in_data),
        .rd_ready   (out2_ready),
        .valid      (out2_valid),
        .data       (out2_data),
        .can_accept (acc2),
        .state      (slot2_state)
    );

`ifdef DEMUX_STATUS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    // Counters saturate rather than wrap so a stuck-high value means "many".
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (wr1 && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
        if (wr2 && (cnt2_q != CNT_MAX)) cnt2_d = cnt2_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif
endmodule

// File: tb/tb_demux8bit2way_buf.sv
// Bench for demux8bit2way_buf: directed scenarios plus randomized traffic against a queue model.
// Counter checks are compiled in when DEMUX_STATUS_EN is defined.
module tb_demux8bit2way_buf;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out1_data, out2_data;
    logic         out1_valid, out2_valid;
    logic         out1_ready = 1'b0;
    logic         out2_ready = 1'b0;
`ifdef DEMUX_STATUS_EN
    logic [7:0]   cnt1, cnt2;
`endif

    always #5 clk = ~clk;

    demux8bit2way_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
`ifdef DEMUX_STATUS_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    // Reference model: per-channel FIFO of words in flight, last delivered word,
    // consumed-word log and acceptance counts.
    logic [W-1:0] exp_q1[$], exp_q2[$];
    logic [W-1:0] cons1[$], cons2[$];
    logic [W-1:0] last1, last2;
    int           n_acc1, n_acc2;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q1.delete(); exp_q2.delete();
        cons1.delete();  cons2.delete();
        last1 = '0; last2 = '0;
        n_acc1 = 0; n_acc2 = 0;
    endtask

    task automatic check_outputs();
        check("out1_valid", out1_valid, exp_q1.size() > 0);
        check("out1_data",  out1_data,  exp_q1.size() > 0 ? exp_q1[0] : last1);
        check("out2_valid", out2_valid, exp_q2.size() > 0);
        check("out2_data",  out2_data,  exp_q2.size() > 0 ? exp_q2[0] : last2);
`ifdef DEMUX_STATUS_EN
        check("cnt1", cnt1, (n_acc1 > 255) ? 255 : n_acc1);
        check("cnt2", cnt2, (n_acc2 > 255) ? 255 : n_acc2);
`endif
    endtask

    // One clock cycle: drive after the falling edge, check in_ready, advance model at the edge,
    // then check registered outputs just after it.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r1, input logic r2, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; out1_ready = r1; out2_ready = r2;
        #1;
        exp_rdy = s ? (exp_q2.size() == 0 || r2) : (exp_q1.size() == 0 || r1);
        check("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (exp_q1.size() > 0 && r1) begin
            last1 = exp_q1.pop_front();
            cons1.push_back(last1);
        end
        if (exp_q2.size() > 0 && r2) begin
            last2 = exp_q2.pop_front();
            cons2.push_back(last2);
        end
        if (acc) begin
            if (!s) begin exp_q1.push_back(d); n_acc1++; end
            else    begin exp_q2.push_back(d); n_acc2++; end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        in_sel = 1'($urandom_range(0, 1));
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);
    endtask

    logic         acc;
    logic         pend_v, pend_s;
    logic [W-1:0] pend_d;

    initial begin
        model_clear();
        do_reset();

        // Channel 1 fills and stalls.
        cycle(1'b1, 1'b0, 8'h88, 1'b0, 1'b0, acc);
        check("t1_acc", acc, 1'b1);
        check("t1_out1_data", out1_data, 8'h88);
        check("t1_out2_valid", out2_valid, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);

        // Channel 2 unaffected by the stalled channel 1.
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, acc);
        check("t2_acc", acc, 1'b1);
        check("t2_out2_data", out2_data, 8'hF0);
        check("t2_out1_data", out1_data, 8'h88);

        // Pass-through refill of a full channel 2.
        cycle(1'b1, 1'b1, 8'hCC, 1'b0, 1'b1, acc);
        check("t3_acc", acc, 1'b1);
        check("t3_out2_valid", out2_valid, 1'b1);
        check("t3_out2_data", out2_data, 8'hCC);
        check("t3_consumed", cons2.size() > 0 ? cons2[cons2.size()-1] : 8'h00, 8'hF0);

        // Drain, then alternating stream at full rate.
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        cycle(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, acc);
        check("t4_acc0", acc, 1'b1);
        check("t4_out1", out1_data, 8'h01);
        cycle(1'b1, 1'b1, 8'h80, 1'b1, 1'b1, acc);
        check("t4_acc1", acc, 1'b1);
        check("t4_out2", out2_data, 8'h80);
        cycle(1'b1, 1'b0, 8'hEC, 1'b1, 1'b1, acc);
        check("t4_acc2", acc, 1'b1);
        check("t4_out1b", out1_data, 8'hEC);

        // Reset with both slots full.
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, acc);
        cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, acc);
        check("t5_both_full", {out1_valid, out2_valid}, 2'b11);
        do_reset();
        check("t5_out1_valid", out1_valid, 1'b0);
        check("t5_out1_data", out1_data, 8'h00);
        check("t5_out2_data", out2_data, 8'h00);

        // Randomized traffic; an unaccepted word is held until accepted.
        pend_v = 1'b0; pend_s = 1'b0; pend_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_s = 1'($urandom_range(0, 1));
                pend_d = 8'($urandom_range(0, 255));
            end
            cycle(pend_v, pend_s, pend_d,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), acc);
            if (acc) pend_v = 1'b0;
        end
        check("rand_order1", cons1.size() + exp_q1.size(), n_acc1);
        check("rand_order2", cons2.size() + exp_q2.size(), n_acc2);

`ifdef DEMUX_STATUS_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, acc);
        end
        check("cnt1_sat", cnt1, 8'hFF);
        check("cnt2_zero", cnt2, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
